// File: rtl/pht_flush_ctrl.sv
// Pattern-history-table flush controller: registers saturating counter updates
// and sweeps every entry to INIT_CTR on request. PHT_FLUSH_STATS_EN adds the drop counter.
module pht_flush_ctrl #(
    parameter int         IWIDTH   = 6,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              flush_req,
    input  logic              upd_valid,
    input  logic [IWIDTH-1:0] upd_index,
    input  logic [1:0]        upd_ctr,
    input  logic              upd_taken,
    output logic              wr_en,
    output logic [IWIDTH-1:0] wr_index,
    output logic [1:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IWIDTH-1:0] sweep_q, sweep_d;
    logic              wr_en_q, wr_en_d;
    logic [IWIDTH-1:0] wr_index_q, wr_index_d;
    logic [1:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic [1:0]        sat_ctr;

    always_comb begin
        sat_ctr = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != 2'b11) sat_ctr = upd_ctr + 2'd1;
        end else begin
            if (upd_ctr != 2'b00) sat_ctr = upd_ctr - 2'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        wr_en_d    = 1'b0;
        wr_index_d = wr_index_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;

        if (en) begin
            done_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (flush_req) begin
                        state_d = FLUSH;
                        sweep_d = '0;
                    end else if (upd_valid) begin
                        wr_en_d    = 1'b1;
                        wr_index_d = upd_index;
                        wr_data_d  = sat_ctr;
                    end
                end
                FLUSH: begin
                    // A restart spends this cycle rewinding; index 0 is written next.
                    if (flush_req) begin
                        sweep_d = '0;
                    end else begin
                        wr_en_d    = 1'b1;
                        wr_index_d = sweep_q;
                        wr_data_d  = INIT_CTR;
                        sweep_d    = sweep_q + 1'b1;
                        if (sweep_q == '1) state_d = DONE;
                    end
                end
                DONE: begin
                    done_d = 1'b1;
                    if (flush_req) begin
                        state_d = FLUSH;
                        sweep_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sweep_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_index_q <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            wr_en_q    <= wr_en_d;
            wr_index_q <= wr_index_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_index = wr_index_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;
    assign busy     = (state_q == FLUSH);

`ifdef PHT_FLUSH_STATS_EN
    logic       drop;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Discarded: update colliding with a flush request in IDLE, or any update in FLUSH/DONE.
    assign drop = en && upd_valid && ((state_q != IDLE) || flush_req);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pht_flush_ctrl.sv
// Self-checking bench for pht_flush_ctrl: scoreboard of expected table writes,
// one task per scenario.
module tb_pht_flush_ctrl;

    localparam int         IW   = 6;
    localparam int         N    = 64;
    localparam logic [1:0] INIT = 2'b01;
`ifdef PHT_FLUSH_STATS_EN
    localparam logic [7:0] EXP_DROP4 = 8'd4;
    localparam logic [7:0] EXP_DROP5 = 8'd5;
`else
    localparam logic [7:0] EXP_DROP4 = 8'd0;
    localparam logic [7:0] EXP_DROP5 = 8'd0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en, flush_req, upd_valid, upd_taken;
    logic [IW-1:0] upd_index;
    logic [1:0]    upd_ctr;
    logic          wr_en, busy, done;
    logic [IW-1:0] wr_index;
    logic [1:0]    wr_data;
    logic [7:0]    drop_cnt;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [1:0]    data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    // update stimulus with hand-derived saturating results
    logic [IW-1:0] t_idx [6] = '{6'd5, 6'd17, 6'd63, 6'd0, 6'd42, 6'd8};
    logic [1:0]    t_ctr [6] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01};
    logic          t_tk  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]    t_exp [6] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10};

    always #5 clk = ~clk;

    pht_flush_ctrl #(.IWIDTH(IW), .INIT_CTR(INIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .flush_req (flush_req),
        .upd_valid (upd_valid),
        .upd_index (upd_index),
        .upd_ctr   (upd_ctr),
        .upd_taken (upd_taken),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .drop_cnt  (drop_cnt)
    );

    task automatic drive_idle();
        en        = 1'b1;
        flush_req = 1'b0;
        upd_valid = 1'b0;
        upd_index = '0;
        upd_ctr   = '0;
        upd_taken = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic push_sweep();
        for (int i = 0; i < N; i++) exp_q.push_back(wr_t'{idx: i[IW-1:0], data: INIT});
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        tests++;
        if ({wr_en, wr_index, wr_data} !== '0) begin
            fails++;
            $display("FAIL reset_wr: got en=%b idx=%0d data=%b expected all 0", wr_en, wr_index, wr_data);
        end
        tests++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", busy, done);
        end
        tests++;
        if (drop_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_update();
        wr_t e;
        for (int i = 0; i < 6; i++) begin
            upd_valid = 1'b1;
            upd_index = t_idx[i];
            upd_ctr   = t_ctr[i];
            upd_taken = t_tk[i];
            exp_q.push_back(wr_t'{idx: t_idx[i], data: t_exp[i]});
            @(negedge clk);
            e = exp_q.pop_front();
            tests++;
            if (wr_en !== 1'b1 || wr_index !== e.idx || wr_data !== e.data) begin
                fails++;
                $display("FAIL update[%0d]: got en=%b idx=%0d data=%b expected en=1 idx=%0d data=%b",
                         i, wr_en, wr_index, wr_data, e.idx, e.data);
            end
        end
        upd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (wr_en !== 1'b0) begin
            fails++;
            $display("FAIL update_idle: got wr_en=%b expected 0", wr_en);
        end
    endtask

    task automatic test_sweep();
        wr_t e;
        int  busy_n = 1;
        int  wr_n = 0, done_n = 0, last_wr = -1, done_at = -1;
        flush_req = 1'b1;
        push_sweep();
        @(negedge clk);
        flush_req = 1'b0;
        tests++;
        if (busy !== 1'b1 || wr_en !== 1'b0) begin
            fails++;
            $display("FAIL sweep_entry: got busy=%b wr_en=%b expected 1 0", busy, wr_en);
        end
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_n++;
                done_at = c;
            end
            if (wr_en === 1'b1) begin
                wr_n++;
                last_wr = c;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sweep_extra_write: got idx=%0d expected no write", wr_index);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_index !== e.idx || wr_data !== e.data) begin
                        fails++;
                        $display("FAIL sweep_write: got idx=%0d data=%b expected idx=%0d data=%b",
                                 wr_index, wr_data, e.idx, e.data);
                    end
                end
            end
        end
        tests++;
        if (wr_n != N || last_wr != N || exp_q.size() != 0) begin
            fails++;
            $display("FAIL sweep_count: got writes=%0d last=%0d left=%0d expected %0d %0d 0",
                     wr_n, last_wr, exp_q.size(), N, N);
        end
        tests++;
        if (busy_n != N) begin
            fails++;
            $display("FAIL sweep_busy_cycles: got %0d expected %0d", busy_n, N);
        end
        tests++;
        if (done_n != 1 || done_at != last_wr + 1) begin
            fails++;
            $display("FAIL sweep_done: got pulses=%0d at=%0d expected 1 at %0d", done_n, done_at, last_wr + 1);
        end
        exp_q.delete();
    endtask

    task automatic test_collision();
        wr_t e;
        apply_reset();
        flush_req = 1'b1;
        upd_valid = 1'b1;
        upd_index = 6'd9;
        upd_ctr   = 2'b10;
        upd_taken = 1'b1;
        push_sweep();
        @(negedge clk);
        flush_req = 1'b0;
        upd_valid = 1'b0;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL coll_extra_write: got idx=%0d data=%b expected no write", wr_index, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_index !== e.idx || wr_data !== e.data) begin
                        fails++;
                        $display("FAIL coll_write: got idx=%0d data=%b expected idx=%0d data=%b",
                                 wr_index, wr_data, e.idx, e.data);
                    end
                end
            end
            upd_valid = (c >= 5 && c <= 7);
            if (exp_q.size() == 0) break;
        end
        upd_valid = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL coll_timeout: got %0d writes outstanding expected 0", exp_q.size());
        end
        tests++;
        if (drop_cnt !== EXP_DROP4) begin
            fails++;
            $display("FAIL coll_drop_cnt: got %0d expected %0d", drop_cnt, EXP_DROP4);
        end
        // DONE now: flush and update together restart the sweep and still pulse done
        flush_req = 1'b1;
        upd_valid = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        upd_valid = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b1 || wr_en !== 1'b0) begin
            fails++;
            $display("FAIL done_flush: got done=%b busy=%b wr_en=%b expected 1 1 0", done, busy, wr_en);
        end
        tests++;
        if (drop_cnt !== EXP_DROP5) begin
            fails++;
            $display("FAIL done_drop_cnt: got %0d expected %0d", drop_cnt, EXP_DROP5);
        end
        exp_q.delete();
    endtask

    task automatic test_restart_stall();
        wr_t e;
        apply_reset();
        flush_req = 1'b1;
        for (int i = 0; i < 20; i++) exp_q.push_back(wr_t'{idx: i[IW-1:0], data: INIT});
        @(negedge clk);
        flush_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests++;
            if (wr_en !== 1'b1 || wr_index !== e.idx || wr_data !== e.data) begin
                fails++;
                $display("FAIL pre_restart[%0d]: got en=%b idx=%0d data=%b expected en=1 idx=%0d data=%b",
                         i, wr_en, wr_index, wr_data, e.idx, e.data);
            end
        end
        flush_req = 1'b1;
        push_sweep();
        @(negedge clk);
        flush_req = 1'b0;
        tests++;
        if (wr_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL restart_cycle: got wr_en=%b busy=%b done=%b expected 0 1 0", wr_en, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests++;
            if (wr_en !== 1'b1 || wr_index !== e.idx || wr_data !== e.data) begin
                fails++;
                $display("FAIL restart_write[%0d]: got en=%b idx=%0d data=%b expected en=1 idx=%0d data=%b",
                         i, wr_en, wr_index, wr_data, e.idx, e.data);
            end
        end
        en        = 1'b0;
        flush_req = 1'b1;
        upd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (wr_en !== 1'b0 || busy !== 1'b1 || wr_index !== 6'd9) begin
                fails++;
                $display("FAIL stall[%0d]: got wr_en=%b busy=%b idx=%0d expected 0 1 9", i, wr_en, busy, wr_index);
            end
        end
        en        = 1'b1;
        flush_req = 1'b0;
        upd_valid = 1'b0;
        for (int i = 10; i < N; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests++;
            if (wr_en !== 1'b1 || wr_index !== e.idx || wr_data !== e.data) begin
                fails++;
                $display("FAIL resume_write[%0d]: got en=%b idx=%0d data=%b expected en=1 idx=%0d data=%b",
                         i, wr_en, wr_index, wr_data, e.idx, e.data);
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
            fails++;
            $display("FAIL restart_done: got done=%b wr_en=%b busy=%b drop=%0d expected 1 0 0 0",
                     done, wr_en, busy, drop_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_sweep();
        int done_n = 0, wr_n = 0;
        apply_reset();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({wr_en, wr_index, wr_data, busy, done, drop_cnt} !== '0) begin
            fails++;
            $display("FAIL async_reset: got en=%b idx=%0d data=%b busy=%b done=%b drop=%0d expected all 0",
                     wr_en, wr_index, wr_data, busy, done, drop_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_n++;
            if (wr_en === 1'b1) wr_n++;
        end
        tests++;
        if (done_n != 0 || wr_n != 0) begin
            fails++;
            $display("FAIL reset_abandon: got done=%0d writes=%0d expected 0 0", done_n, wr_n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_update();
        test_sweep();
        test_collision();
        test_restart_stall();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
